// File: rtl/euler_rotation_matrix.sv
// euler_rotation_matrix
// Builds R = Rz(gamma) * Ry(beta) * Rx(alpha) once per frame. A single rotation-mode CORDIC
// is time-shared across the three angles to get sin/cos, then one multiplier forms the
// fourteen products needed for the nine matrix entries. The matrix and the translation
// captured at frame start are published together with a one-cycle done strobe.
module euler_rotation_matrix #(
    parameter int WI = 8,
    parameter int WF = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic [11:0]             alpha,
    input  logic [11:0]             beta,
    input  logic [11:0]             gamma,
    input  logic [WI+WF-1:0]        x,
    input  logic [WI+WF-1:0]        y,
    input  logic [WI+WF-1:0]        z,
    output logic signed [WI+WF-1:0] m00,
    output logic signed [WI+WF-1:0] m01,
    output logic signed [WI+WF-1:0] m02,
    output logic signed [WI+WF-1:0] m10,
    output logic signed [WI+WF-1:0] m11,
    output logic signed [WI+WF-1:0] m12,
    output logic signed [WI+WF-1:0] m20,
    output logic signed [WI+WF-1:0] m21,
    output logic signed [WI+WF-1:0] m22,
    output logic [WI+WF-1:0]        tx,
    output logic [WI+WF-1:0]        ty,
    output logic [WI+WF-1:0]        tz,
    output logic                    busy,
    output logic                    done
);

    localparam int W   = WI + WF;
    localparam int SHR = 14 - WF;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ITER  = 3'd2;
    localparam logic [2:0] ST_MUL   = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    // CORDIC gain compensation and reduction constants, 14 fraction bits
    localparam logic signed [17:0] CORDIC_K = 18'sh026DD;
    localparam logic signed [17:0] TWO_PI   = 18'sh19200;
    localparam logic signed [17:0] PI_FIX   = 18'sh0C900;
    // Quadrant boundaries in the 4.8 angle format
    localparam logic [11:0] TH_3PI2 = 12'h4B6;
    localparam logic [11:0] TH_PI2  = 12'h192;

    localparam logic signed [W-1:0] ONE_FIX = {{(WI-1){1'b0}}, 1'b1, {WF{1'b0}}};

    // atan(2^-i) with 14 fraction bits
    function automatic logic signed [17:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = 18'sd12868;
            4'd1:    atan_lut = 18'sd7596;
            4'd2:    atan_lut = 18'sd4014;
            4'd3:    atan_lut = 18'sd2037;
            4'd4:    atan_lut = 18'sd1023;
            4'd5:    atan_lut = 18'sd512;
            4'd6:    atan_lut = 18'sd256;
            4'd7:    atan_lut = 18'sd128;
            4'd8:    atan_lut = 18'sd64;
            4'd9:    atan_lut = 18'sd32;
            4'd10:   atan_lut = 18'sd16;
            4'd11:   atan_lut = 18'sd8;
            4'd12:   atan_lut = 18'sd4;
            4'd13:   atan_lut = 18'sd2;
            default: atan_lut = 18'sd0;
        endcase
    endfunction

    // Undo the quadrant fold, drop to WF fraction bits and clamp to +/-1.0
    function automatic logic signed [W-1:0] to_fix(input logic signed [17:0] v,
                                                   input logic neg);
        logic signed [31:0] t;
        logic signed [31:0] one;
        t   = {{14{v[17]}}, v};
        one = 32'sd1 <<< WF;
        if (neg) begin
            t = -t;
        end else begin
            t = t;
        end
        t = t >>> SHR;
        if (t > one) begin
            to_fix = W'(one);
        end else if (t < -one) begin
            to_fix = W'(-one);
        end else begin
            to_fix = W'(t);
        end
    endfunction

    logic [2:0]         state_r;
    logic [1:0]         k_r;
    logic [3:0]         cnt_r;
    logic [11:0]        alpha_r, beta_r, gamma_r;
    logic [W-1:0]       xl_r, yl_r, zl_r;
    logic signed [17:0] cx_r, cy_r, ang_r;
    logic               neg_r;
    logic signed [W-1:0] trig_r [6];
    logic signed [W-1:0] prod_r [14];

    logic [11:0]          theta_s;
    logic signed [17:0]   theta_ext_s;
    logic signed [17:0]   red_ang_s;
    logic                 red_neg_s;
    logic                 d_pos_s;
    logic signed [17:0]   cx_sh_s, cy_sh_s, atan_s;
    logic signed [17:0]   cx_nx_s, cy_nx_s, ang_nx_s;
    logic signed [W-1:0]  cos_fix_s, sin_fix_s;
    logic signed [W-1:0]  op_a_s, op_b_s;
    logic signed [2*W-1:0] prod_full_s;
    logic signed [W-1:0]  prod_s;

    // Angle selection and quadrant reduction into [-pi/2, pi/2]
    always_comb begin
        theta_s     = gamma_r;
        red_ang_s   = 18'sd0;
        red_neg_s   = 1'b0;
        case (k_r)
            2'd0:    theta_s = alpha_r;
            2'd1:    theta_s = beta_r;
            default: theta_s = gamma_r;
        endcase
        theta_ext_s = $signed({theta_s, 6'b000000});
        if (theta_s > TH_3PI2) begin
            red_ang_s = theta_ext_s - TWO_PI;
            red_neg_s = 1'b0;
        end else if (theta_s > TH_PI2) begin
            red_ang_s = theta_ext_s - PI_FIX;
            red_neg_s = 1'b1;
        end else begin
            red_ang_s = theta_ext_s;
            red_neg_s = 1'b0;
        end
    end

    // One CORDIC micro-rotation plus the final conversion of its result
    always_comb begin
        d_pos_s = ~ang_r[17];
        cx_sh_s = cx_r >>> cnt_r;
        cy_sh_s = cy_r >>> cnt_r;
        atan_s  = atan_lut(cnt_r);
        if (d_pos_s) begin
            cx_nx_s  = cx_r - cy_sh_s;
            cy_nx_s  = cy_r + cx_sh_s;
            ang_nx_s = ang_r - atan_s;
        end else begin
            cx_nx_s  = cx_r + cy_sh_s;
            cy_nx_s  = cy_r - cx_sh_s;
            ang_nx_s = ang_r + atan_s;
        end
        cos_fix_s = to_fix(cx_nx_s, neg_r);
        sin_fix_s = to_fix(cy_nx_s, neg_r);
    end

    // Operand schedule for the shared multiplier (trig_r: ca sa cb sb cg sg)
    always_comb begin
        op_a_s = '0;
        op_b_s = '0;
        case (cnt_r)
            4'd0:    begin op_a_s = trig_r[1];  op_b_s = trig_r[3]; end
            4'd1:    begin op_a_s = trig_r[0];  op_b_s = trig_r[3]; end
            4'd2:    begin op_a_s = trig_r[2];  op_b_s = trig_r[4]; end
            4'd3:    begin op_a_s = trig_r[2];  op_b_s = trig_r[5]; end
            4'd4:    begin op_a_s = trig_r[1];  op_b_s = trig_r[2]; end
            4'd5:    begin op_a_s = trig_r[0];  op_b_s = trig_r[2]; end
            4'd6:    begin op_a_s = prod_r[0];  op_b_s = trig_r[4]; end
            4'd7:    begin op_a_s = trig_r[0];  op_b_s = trig_r[5]; end
            4'd8:    begin op_a_s = prod_r[1];  op_b_s = trig_r[4]; end
            4'd9:    begin op_a_s = trig_r[1];  op_b_s = trig_r[5]; end
            4'd10:   begin op_a_s = prod_r[0];  op_b_s = trig_r[5]; end
            4'd11:   begin op_a_s = trig_r[0];  op_b_s = trig_r[4]; end
            4'd12:   begin op_a_s = prod_r[1];  op_b_s = trig_r[5]; end
            4'd13:   begin op_a_s = trig_r[1];  op_b_s = trig_r[4]; end
            default: begin op_a_s = '0;         op_b_s = '0;        end
        endcase
        prod_full_s = op_a_s * op_b_s;
        prod_s      = W'(prod_full_s >>> WF);
    end

    // Sequencer and working registers: capture, three CORDIC passes, product schedule
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            k_r     <= 2'd0;
            cnt_r   <= 4'd0;
            alpha_r <= 12'd0;
            beta_r  <= 12'd0;
            gamma_r <= 12'd0;
            xl_r    <= '0;
            yl_r    <= '0;
            zl_r    <= '0;
            cx_r    <= 18'sd0;
            cy_r    <= 18'sd0;
            ang_r   <= 18'sd0;
            neg_r   <= 1'b0;
            busy    <= 1'b0;
            for (int i = 0; i < 6; i++) trig_r[i] <= '0;
            for (int i = 0; i < 14; i++) prod_r[i] <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        alpha_r <= alpha;
                        beta_r  <= beta;
                        gamma_r <= gamma;
                        xl_r    <= x;
                        yl_r    <= y;
                        zl_r    <= z;
                        k_r     <= 2'd0;
                        busy    <= 1'b1;
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    cx_r    <= CORDIC_K;
                    cy_r    <= 18'sd0;
                    ang_r   <= red_ang_s;
                    neg_r   <= red_neg_s;
                    cnt_r   <= 4'd0;
                    state_r <= ST_ITER;
                end
                ST_ITER: begin
                    cx_r  <= cx_nx_s;
                    cy_r  <= cy_nx_s;
                    ang_r <= ang_nx_s;
                    if (cnt_r == 4'd13) begin
                        trig_r[{k_r, 1'b0}] <= cos_fix_s;
                        trig_r[{k_r, 1'b1}] <= sin_fix_s;
                        cnt_r <= 4'd0;
                        if (k_r == 2'd2) begin
                            state_r <= ST_MUL;
                        end else begin
                            k_r     <= k_r + 2'd1;
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_MUL: begin
                    prod_r[cnt_r] <= prod_s;
                    if (cnt_r == 4'd13) begin
                        cnt_r   <= 4'd0;
                        state_r <= ST_WRITE;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_WRITE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output registers: updated all at once in WRITE so partial results never show
    always_ff @(posedge Clk) begin
        if (Reset) begin
            m00  <= ONE_FIX;
            m01  <= '0;
            m02  <= '0;
            m10  <= '0;
            m11  <= ONE_FIX;
            m12  <= '0;
            m20  <= '0;
            m21  <= '0;
            m22  <= ONE_FIX;
            tx   <= '0;
            ty   <= '0;
            tz   <= '0;
            done <= 1'b0;
        end else if (state_r == ST_WRITE) begin
            m00  <= prod_r[2];
            m10  <= prod_r[3];
            m21  <= prod_r[4];
            m22  <= prod_r[5];
            m01  <= prod_r[6] - prod_r[7];
            m02  <= prod_r[8] + prod_r[9];
            m11  <= prod_r[10] + prod_r[11];
            m12  <= prod_r[12] - prod_r[13];
            m20  <= -trig_r[3];
            tx   <= xl_r;
            ty   <= yl_r;
            tz   <= zl_r;
            done <= 1'b1;
        end else begin
            done <= 1'b0;
        end
    end

endmodule
